// File: rtl/evg_event_logger_pkg.sv
// Shared widths, system-code constants and controller states for the EVG event logger.
// The system-code filter is enabled by defining EVG_EVENT_LOGGER_SYSCODE_FILTER_EN.
package evg_event_logger_pkg;

    localparam int unsigned CODE_W = 8;
    localparam int unsigned SEC_W  = 32;

    localparam logic [CODE_W-1:0] SYSCODE_70 = 8'h70;
    localparam logic [CODE_W-1:0] SYSCODE_71 = 8'h71;
    localparam logic [CODE_W-1:0] SYSCODE_7A = 8'h7A;
    localparam logic [CODE_W-1:0] SYSCODE_7D = 8'h7D;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_LOGGING  = 2'd1,
        ST_STALLED  = 2'd2
    } state_e;

    function automatic logic is_syscode(input logic [CODE_W-1:0] code);
        return (code == SYSCODE_70) || (code == SYSCODE_71) ||
               (code == SYSCODE_7A) || (code == SYSCODE_7D);
    endfunction

endpackage

// File: rtl/evg_event_logger_fifo.sv
// Synchronous log FIFO with a registered head entry; count covers memory plus head.
module evg_event_logger_fifo
    import evg_event_logger_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter int unsigned DATA_W     = 67
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic [CNT_W-1:0]      mem_cnt_c;
    logic                  pop_c;
    logic                  load_c;

    // Head register refills from memory whenever it is empty or being popped.
    always_comb begin
        pop_c       = out_valid_q & rd_ready;
        mem_cnt_c   = count_q - CNT_W'(out_valid_q);
        load_c      = (mem_cnt_c != '0) && (!out_valid_q || pop_c);
        wr_ptr_d    = wr_ptr_q + DEPTH_LOG2'(wr_en);
        rd_ptr_d    = rd_ptr_q + DEPTH_LOG2'(load_c);
        count_d     = count_q + CNT_W'(wr_en) - CNT_W'(pop_c);
        out_valid_d = load_c ? 1'b1 : (pop_c ? 1'b0 : out_valid_q);
        out_data_d  = load_c ? mem_q[rd_ptr_q] : out_data_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_valid = out_valid_q;
    assign rd_data  = out_data_q;
    assign count    = count_q;

endmodule

// File: rtl/evg_event_logger.sv
// Timestamps EVG transmitter event codes into an AXI-Stream log FIFO with overflow tracking.
// Define EVG_EVENT_LOGGER_SYSCODE_FILTER_EN to suppress logging of system codes 0x70/0x71/0x7A/0x7D.
module evg_event_logger
    import evg_event_logger_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH_LOG2 = 9,
    parameter int unsigned TICKS_WIDTH     = 27
) (
    input  logic                                 evgTxClk,
    input  logic                                 evgTxReset_n,
    input  logic [15:0]                          evgTxData,
    input  logic [1:0]                           evgTxCharIsK,
    input  logic [SEC_W-1:0]                     evgSeconds,
    input  logic                                 enable,
    input  logic                                 clear,
    output logic [SEC_W+TICKS_WIDTH+CODE_W-1:0]  logTDATA,
    output logic                                 logTVALID,
    input  logic                                 logTREADY,
    output logic [FIFO_DEPTH_LOG2:0]             fifoCount,
    output logic [15:0]                          overflowCount,
    output logic                                 stalled
);

    localparam int unsigned DATA_W = SEC_W + TICKS_WIDTH + CODE_W;
    localparam int unsigned CNT_W  = FIFO_DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** FIFO_DEPTH_LOG2);
    localparam logic [CNT_W-1:0] HALF  = DEPTH >> 1;

    state_e                 state_q, state_d;
    logic [TICKS_WIDTH-1:0] ticks_q, ticks_d, ticks_c;
    logic [SEC_W-1:0]       sec_prev_q;
    logic [15:0]            ovf_q, ovf_d;
    logic                   stalled_q, stalled_d;
    logic [CODE_W-1:0]      code_c;
    logic                   is_event_c;
    logic                   push_c;
    logic                   drop_c;
    logic [CNT_W-1:0]       fifo_count;
    logic                   unused_bits;

    assign unused_bits = ^{evgTxData[15:8], evgTxCharIsK[1]};

    // Ticks restart in the very cycle the seconds value changes.
    always_comb begin
        ticks_c = (evgSeconds != sec_prev_q) ? '0 : ticks_q;
        ticks_d = (&ticks_c) ? ticks_c : ticks_c + TICKS_WIDTH'(1);
    end

    always_comb begin
        code_c     = evgTxData[CODE_W-1:0];
        is_event_c = !evgTxCharIsK[0] && (code_c != '0);
`ifdef EVG_EVENT_LOGGER_SYSCODE_FILTER_EN
        is_event_c = is_event_c && !is_syscode(code_c);
`else
        is_event_c = is_event_c;
`endif
    end

    always_comb begin
        state_d = state_q;
        push_c  = 1'b0;
        drop_c  = 1'b0;
        case (state_q)
            ST_DISABLED: begin
                if (enable) state_d = ST_LOGGING;
            end
            ST_LOGGING: begin
                if (is_event_c) begin
                    if (fifo_count == DEPTH) begin
                        drop_c  = 1'b1;
                        state_d = ST_STALLED;
                    end else begin
                        push_c = 1'b1;
                    end
                end
            end
            ST_STALLED: begin
                drop_c = is_event_c;
                if (fifo_count <= HALF) state_d = ST_LOGGING;
            end
            default: state_d = ST_DISABLED;
        endcase
        if (!enable) state_d = ST_DISABLED;
        // Flush wins over everything, including an event in the same cycle.
        if (clear) begin
            push_c  = 1'b0;
            drop_c  = 1'b0;
            state_d = enable ? ST_LOGGING : ST_DISABLED;
        end
        if (clear) begin
            ovf_d = '0;
        end else if (drop_c && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end else begin
            ovf_d = ovf_q;
        end
        stalled_d = (state_d == ST_STALLED);
    end

    always_ff @(posedge evgTxClk) begin
        if (!evgTxReset_n) begin
            state_q    <= ST_DISABLED;
            ticks_q    <= '0;
            sec_prev_q <= '0;
            ovf_q      <= '0;
            stalled_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ticks_q    <= ticks_d;
            sec_prev_q <= evgSeconds;
            ovf_q      <= ovf_d;
            stalled_q  <= stalled_d;
        end
    end

    evg_event_logger_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .clk      (evgTxClk),
        .rst_n    (evgTxReset_n),
        .flush    (clear),
        .wr_en    (push_c),
        .wr_data  ({evgSeconds, ticks_c, code_c}),
        .rd_ready (logTREADY),
        .rd_valid (logTVALID),
        .rd_data  (logTDATA),
        .count    (fifo_count)
    );

    assign fifoCount     = fifo_count;
    assign overflowCount = ovf_q;
    assign stalled       = stalled_q;

endmodule
